// File: rtl/xor_stream_descrambler_if.sv
// xor_stream_descrambler_if: byte-stream handshake and seed-load bundle for the descrambler
interface xor_stream_descrambler_if;
  logic       seed_load;
  logic [7:0] seed_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] o;
  modport master (
    output seed_load, seed_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, o
  );
  modport slave (
    input  seed_load, seed_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, o
  );
endinterface

// File: rtl/xor_stream_descrambler.sv
// xor_stream_descrambler: XOR bytes with a Galois-LFSR keystream behind a one-deep output register (optional Count via XORDS_COUNT_EN)
module xor_stream_descrambler #(
  parameter logic [7:0] SEED = 8'hA5,
  parameter logic [7:0] TAPS = 8'hB8
) (
  input  logic CLK,
  input  logic Reset,
`ifdef XORDS_COUNT_EN
  output logic [15:0] count,
`endif
  xor_stream_descrambler_if.slave bus
);
  logic [7:0] k, k_adv, k_next, o_q, o_next;
  logic       ov, ov_next, accept;
  assign bus.in_ready  = !Reset && !bus.seed_load && (!ov || bus.out_ready);
  assign bus.out_valid = ov;
  assign bus.o         = o_q;
  assign accept        = bus.in_valid && bus.in_ready;
  // Keystream advance, seed substitution and output-register update; a zero seed would lock the LFSR, so it is replaced
  always_comb begin
    k_adv   = k[0] ? ((k >> 1) ^ TAPS) : (k >> 1);
    k_next  = bus.seed_load ? ((bus.seed_in == 8'h00) ? SEED : bus.seed_in) : accept ? k_adv : k;
    o_next  = accept ? (bus.in_data ^ k) : o_q;
    ov_next = accept ? 1'b1 : (ov && bus.out_ready) ? 1'b0 : ov;
  end
  // State registers; reset discards any byte mid-handshake
  always_ff @(posedge CLK) begin
    if (Reset) begin
      k   <= SEED;
      o_q <= 8'h00;
      ov  <= 1'b0;
    end else begin
      k   <= k_next;
      o_q <= o_next;
      ov  <= ov_next;
    end
  end
`ifdef XORDS_COUNT_EN
  // Accepted-byte counter, wraps naturally and survives seed loads
  always_ff @(posedge CLK) begin
    if (Reset) count <= 16'h0000;
    else if (accept) count <= count + 16'h0001;
  end
`endif
endmodule

// File: doc/xor_stream_descrambler.md
# xor_stream_descrambler

Byte-stream descrambler for the datapath's serial/peripheral input path. Each accepted byte is XORed with an 8-bit Galois-LFSR keystream, built on the existing 8-bit two-input XOR primitive, to recover plaintext from a scrambled stream. Because XOR is self-inverse, the same block also serves as the transmit-side scrambler. The block provides valid/ready handshakes on both sides with a one-deep output register, so it can be placed between a byte source and any consumer without combinational paths from input to output data.

## Interface
- SEED, 8'hA5, LFSR value after Reset, and the substitute value when a zero seed is loaded
- TAPS, 8'hB8, Galois feedback mask (maximal length 255 with default)
- CLK  input  1  sole clock, rising-edge
- Reset  input  1  synchronous, active-high
- SeedLoad  input  1  load SeedIn into the LFSR this cycle
- SeedIn  input  8  new seed
- InValid  input  1  In holds a byte
- InReady  output  1  block accepts In this cycle
- In  input  8  scrambled byte
- OutValid  output  1  O holds a descrambled byte
- OutReady  input  1  consumer accepts O this cycle
- O  output  8  descrambled byte
- Count  output  16  accepted-byte counter (only with XORDS_COUNT_EN)

## Operation
- Key register K (8 bit), output register O, flag OutValid.
- LFSR advance: if K[0] then K <= (K >> 1) ^ TAPS, else K <= K >> 1.
- InReady = !SeedLoad && (!OutValid || OutReady). This is combinational and contains no dependence on InValid.
- Accept condition: InValid && InReady. On accept, O <= In ^ K, OutValid <= 1, and K advances. The current K is used first, then advanced.
- Drain: OutValid && OutReady && no accept. OutValid <= 0 and O holds its value.
- Simultaneous drain and accept: O is replaced by the new byte and OutValid stays 1. Full throughput is one byte per cycle.
- Stall: OutValid && !OutReady. O and OutValid hold, and InReady is 0.
- SeedLoad:
  - K <= (SeedIn == 0) ? SEED : SeedIn.
  - No byte is accepted that cycle.
  - O and OutValid are unaffected, and a pending output may still drain.
- K never becomes 0.
- Reset:
  - K = SEED, OutValid = 0, O = 8'h00, Count = 0.
  - Reset overrides SeedLoad and any handshake. A byte that is mid-handshake is discarded.
- Data must stay stable while OutValid && !OutReady. The upstream side may change In freely while InReady is 0.

## Timing
- Latency: one cycle, from the accept edge to OutValid/O being valid after that edge.
- With no stall, the keystream period is 255 bytes for the default TAPS.
- All outputs are registered except InReady.
- InReady is 0 during the Reset cycle and returns to 1 in the first cycle after Reset deasserts.

## Configuration
- Macro: XORDS_COUNT_EN.
- Defined:
  - Count port exists and increments by 1 on every accept.
  - Wraps from 16'hFFFF to 0.
  - Cleared by Reset.
  - Not cleared by SeedLoad.
- Undefined: the Count port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then with OutReady=1, feed In=00, 00, FF on consecutive cycles. Required: O=A5, EA, 8A, each one cycle after its accept, with OutValid continuous.
- Reset, then hold OutReady=0 and feed In=00. Required: O=A5 and OutValid=1 holding; InReady=0 while the stall lasts. Raise OutReady: InReady returns to 1 and a new byte is accepted in the same cycle the old one drains.
- SeedLoad with SeedIn=3C, then feed In=00. Required: O=3C. SeedLoad with SeedIn=00, then feed In=00. Required: O=A5 (zero seed replaced by SEED). InReady=0 in both SeedLoad cycles.
- Loopback: chain two instances with the same SEED and feed 300 bytes from a counting pattern. Required: the second instance's O equals the original bytes. Also check that the first instance's keystream repeats after 255 bytes.
- Assert Reset while OutValid=1 and K is mid-sequence. Required: the next cycle has OutValid=0, O=00, and the first byte after reset is descrambled with A5.
- With XORDS_COUNT_EN defined: accept 3 bytes and require Count=3. Force 65536 accepts and require Count to wrap to 0. Confirm SeedLoad leaves Count unchanged.
